// File: rtl/run_control_pkg.sv
// run_control_pkg
//   Shared types for the run-control stage: the FSM state encoding that is
//   also exported on the STATE output, and its width.
package run_control_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        HOLD  = 3'd0,
        IDLE  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        STEP  = 3'd4,
        DONE  = 3'd5
    } run_state_t;

endpackage

// File: rtl/run_control_if.sv
// run_control_if
//   Control/status bundle between a run-control stage and whatever drives it
//   (testbench, debug host).
//   master: drives RUN, HALT_REQ, STEP, HALTED_IN; observes the status outputs.
//   slave : the run-control stage; receives requests, drives CPU_RESET,
//           CPU_EN, STATE, CYCLE_COUNT, DONE, TIMEOUT.
interface run_control_if
    import run_control_pkg::*;
#(
    parameter int CYCLE_W = 32
) ();

    logic               RUN;
    logic               HALT_REQ;
    logic               STEP;
    logic               HALTED_IN;
    logic               CPU_RESET;
    logic               CPU_EN;
    logic [STATE_W-1:0] STATE;
    logic [CYCLE_W-1:0] CYCLE_COUNT;
    logic               DONE;
    logic               TIMEOUT;

    modport master (
        output RUN, HALT_REQ, STEP, HALTED_IN,
        input  CPU_RESET, CPU_EN, STATE, CYCLE_COUNT, DONE, TIMEOUT
    );

    modport slave (
        input  RUN, HALT_REQ, STEP, HALTED_IN,
        output CPU_RESET, CPU_EN, STATE, CYCLE_COUNT, DONE, TIMEOUT
    );

endinterface

// File: rtl/run_control_reset_synchronizer.sv
// reset_synchronizer
//   Asynchronous-assert / synchronous-release reset synchronizer.
//   CLOCK      : destination clock.
//   RESET      : asynchronous active-high reset in.
//   RESET_SYNC : reset out; rises with RESET immediately, falls SYNC_STAGES
//                rising edges after RESET is released.
module reset_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLOCK,
    input  logic RESET,
    output logic RESET_SYNC
);

    logic [SYNC_STAGES-1:0] chain;

    // Zeros enter at bit 0 and walk toward the MSB, which is the output.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            chain <= '1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign RESET_SYNC = chain[SYNC_STAGES-1];

endmodule

// File: rtl/run_control.sv
// run_control
//   Run-control stage behind the clock generator. Converts the asynchronous
//   board reset into a synchronously released CPU reset and gates CPU
//   execution through a clock-enable (run / pause / single-step /
//   halt-detect / cycle-budget timeout). Counts enabled cycles.
//   CLOCK, RESET : clock and asynchronous active-high reset.
//   bus (slave)  : RUN, HALT_REQ, STEP, HALTED_IN in;
//                  CPU_RESET, CPU_EN, STATE, CYCLE_COUNT, DONE, TIMEOUT out.
module run_control
    import run_control_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int RESET_CYCLES = 4,
    parameter int CYCLE_W      = 32,
    parameter int MAX_CYCLES   = 0
) (
    input  logic          CLOCK,
    input  logic          RESET,
    run_control_if.slave  bus
);

    localparam int               HOLD_W      = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CYCLE_W-1:0] BUDGET_LAST = CYCLE_W'(MAX_CYCLES - 1);
    localparam logic [CYCLE_W-1:0] COUNT_MAX   = '1;

    run_state_t         state;
    run_state_t         next_state;
    logic               rst_sync;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [CYCLE_W-1:0] cycle_cnt;
    logic               run_q;
    logic               timeout_q;
    logic               timeout_set;
    logic               cpu_en;
    logic               hold_done;
    logic               budget_hit;
    logic               run_rise;

    reset_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .RESET_SYNC (rst_sync)
    );

    // The hold count only starts once the synchronized reset has dropped.
    assign hold_done  = !rst_sync && (hold_cnt == HOLD_LAST);
    // Compared against the pre-increment count, so the final count lands
    // exactly on MAX_CYCLES.
    assign budget_hit = (MAX_CYCLES != 0) && (cycle_cnt == BUDGET_LAST);
    assign run_rise   = bus.RUN && !run_q;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state <= HOLD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        timeout_set = 1'b0;
        case (state)
            HOLD: begin
                if (hold_done) next_state = IDLE;
            end
            IDLE: begin
                if (bus.RUN)       next_state = RUN;
                else if (bus.STEP) next_state = STEP;
            end
            RUN: begin
                if (bus.HALTED_IN) begin
                    next_state = DONE;
                end else if (budget_hit) begin
                    next_state  = DONE;
                    timeout_set = 1'b1;
                end else if (bus.HALT_REQ || !bus.RUN) begin
                    next_state = PAUSE;
                end
            end
            PAUSE: begin
                // Only a fresh RUN edge resumes; a level held through
                // HALT_REQ keeps us paused.
                if (run_rise)      next_state = RUN;
                else if (bus.STEP) next_state = STEP;
            end
            STEP: begin
                if (bus.HALTED_IN) begin
                    next_state = DONE;
                end else if (budget_hit) begin
                    next_state  = DONE;
                    timeout_set = 1'b1;
                end else begin
                    next_state = PAUSE;
                end
            end
            DONE: begin
                next_state = DONE;
            end
            default: begin
                next_state = HOLD;
            end
        endcase
    end

    // Outputs decode the state register only; no input reaches them
    // combinationally.
    always_comb begin
        cpu_en          = (state == RUN) || (state == STEP);
        bus.CPU_EN      = cpu_en;
        bus.CPU_RESET   = (state == HOLD);
        bus.DONE        = (state == DONE);
        bus.TIMEOUT     = timeout_q;
        bus.STATE       = state;
        bus.CYCLE_COUNT = cycle_cnt;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            hold_cnt  <= '0;
            cycle_cnt <= '0;
            run_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            run_q <= bus.RUN;
            if ((state == HOLD) && !rst_sync) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (cpu_en && (cycle_cnt != COUNT_MAX)) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_run_control.sv
// tb_run_control
//   Bench for run_control. Two instances share CLOCK and RESET: "A" with an
//   unlimited budget and "B" with MAX_CYCLES=8. A behavioural model tracks
//   both and is compared against every output on each falling edge; directed
//   sequences add hand-computed literal expectations.
module tb_run_control;
    import run_control_pkg::*;

    localparam int SYNC     = 2;
    localparam int RC       = 4;
    localparam int CW       = 32;
    localparam int BUDGET_B = 8;
    localparam longint unsigned CNT_MAX = (64'd1 << CW) - 1;

    logic CLOCK = 1'b0;
    logic RESET = 1'b0;

    always #5 CLOCK = ~CLOCK;

    run_control_if #(.CYCLE_W(CW)) bus_a ();
    run_control_if #(.CYCLE_W(CW)) bus_b ();

    run_control #(
        .SYNC_STAGES (SYNC),
        .RESET_CYCLES(RC),
        .CYCLE_W     (CW),
        .MAX_CYCLES  (0)
    ) dut_a (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus_a)
    );

    run_control #(
        .SYNC_STAGES (SYNC),
        .RESET_CYCLES(RC),
        .CYCLE_W     (CW),
        .MAX_CYCLES  (BUDGET_B)
    ) dut_b (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    int unsigned     m_budget   [2] = '{0, BUDGET_B};
    run_state_t      m_state    [2];
    longint unsigned m_cnt      [2];
    bit              m_done     [2];
    bit              m_to       [2];
    bit              m_prev_run [2];
    int              m_rel      [2];

    function automatic void model_clear(input int i);
        m_state[i]    = HOLD;
        m_cnt[i]      = 0;
        m_done[i]     = 1'b0;
        m_to[i]       = 1'b0;
        m_prev_run[i] = 1'b0;
        m_rel[i]      = 0;
    endfunction

    function automatic void model_edge(input int i, input logic run, input logic hreq,
                                       input logic step, input logic hin);
        bit exhausted;
        if (m_state[i] == HOLD) begin
            // CPU reset lasts SYNC + RC edges after the release of RESET.
            m_rel[i]++;
            if (m_rel[i] == SYNC + RC) m_state[i] = IDLE;
        end else if (m_state[i] == RUN || m_state[i] == STEP) begin
            if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
            exhausted = (m_budget[i] != 0) && (m_cnt[i] == m_budget[i]);
            if (hin) begin
                m_state[i] = DONE;
                m_done[i]  = 1'b1;
            end else if (exhausted) begin
                m_state[i] = DONE;
                m_done[i]  = 1'b1;
                m_to[i]    = 1'b1;
            end else if (m_state[i] == STEP || hreq || !run) begin
                m_state[i] = PAUSE;
            end
        end else if (m_state[i] == IDLE) begin
            if (run)       m_state[i] = RUN;
            else if (step) m_state[i] = STEP;
        end else if (m_state[i] == PAUSE) begin
            if (run && !m_prev_run[i]) m_state[i] = RUN;
            else if (step)             m_state[i] = STEP;
        end
        m_prev_run[i] = run;
    endfunction

    always @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            model_clear(0);
            model_clear(1);
        end else begin
            model_edge(0, bus_a.RUN, bus_a.HALT_REQ, bus_a.STEP, bus_a.HALTED_IN);
            model_edge(1, bus_b.RUN, bus_b.HALT_REQ, bus_b.STEP, bus_b.HALTED_IN);
        end
    end

    function automatic void compare(input int i, input string tag, input logic [2:0] st,
                                    input logic cr, input logic en, input logic [CW-1:0] cnt,
                                    input logic dn, input logic to);
        chk($sformatf("%s.STATE", tag), st, m_state[i]);
        chk($sformatf("%s.CPU_RESET", tag), cr, m_state[i] == HOLD);
        chk($sformatf("%s.CPU_EN", tag), en, (m_state[i] == RUN) || (m_state[i] == STEP));
        chk($sformatf("%s.CYCLE_COUNT", tag), cnt, m_cnt[i]);
        chk($sformatf("%s.DONE", tag), dn, m_done[i]);
        chk($sformatf("%s.TIMEOUT", tag), to, m_to[i]);
    endfunction

    always @(negedge CLOCK) begin
        compare(0, "A", bus_a.STATE, bus_a.CPU_RESET, bus_a.CPU_EN, bus_a.CYCLE_COUNT,
                bus_a.DONE, bus_a.TIMEOUT);
        compare(1, "B", bus_b.STATE, bus_b.CPU_RESET, bus_b.CPU_EN, bus_b.CYCLE_COUNT,
                bus_b.DONE, bus_b.TIMEOUT);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK);
        #2;
    endtask

    task automatic release_check(input string tag);
        for (int e = 1; e <= SYNC + RC; e++) begin
            tick(1);
            if (e < SYNC + RC) begin
                chk($sformatf("%s.cpu_reset_e%0d", tag, e), bus_a.CPU_RESET, 1'b1);
            end else begin
                chk($sformatf("%s.cpu_reset_e%0d", tag, e), bus_a.CPU_RESET, 1'b0);
                chk($sformatf("%s.state_idle", tag), bus_a.STATE, 3'd1);
            end
            chk($sformatf("%s.cpu_en_e%0d", tag, e), bus_a.CPU_EN, 1'b0);
        end
    endtask

    initial begin
        model_clear(0);
        model_clear(1);
        bus_a.RUN = 1'b0; bus_a.HALT_REQ = 1'b0; bus_a.STEP = 1'b0; bus_a.HALTED_IN = 1'b0;
        bus_b.RUN = 1'b0; bus_b.HALT_REQ = 1'b0; bus_b.STEP = 1'b0; bus_b.HALTED_IN = 1'b0;

        // Reset state, visible without any clock edge.
        #1 RESET = 1'b1;
        #1;
        chk("rst.CPU_RESET",   bus_a.CPU_RESET,   1'b1);
        chk("rst.CPU_EN",      bus_a.CPU_EN,      1'b0);
        chk("rst.STATE",       bus_a.STATE,       3'd0);
        chk("rst.CYCLE_COUNT", bus_a.CYCLE_COUNT, 32'd0);
        chk("rst.DONE",        bus_a.DONE,        1'b0);
        chk("rst.TIMEOUT",     bus_a.TIMEOUT,     1'b0);
        RESET = 1'b0;

        // Scenario 1: reset release sequence.
        release_check("rel1");

        // Scenario 4: timeout on instance B (budget 8).
        bus_b.RUN = 1'b1;
        tick(1);
        chk("to.state_run", bus_b.STATE, 3'd2);
        chk("to.en_1", bus_b.CPU_EN, 1'b1);
        for (int k = 1; k <= BUDGET_B; k++) begin
            tick(1);
            if (k < BUDGET_B) begin
                chk($sformatf("to.en_%0d", k + 1), bus_b.CPU_EN, 1'b1);
            end else begin
                chk("to.state_done", bus_b.STATE, 3'd5);
                chk("to.count",      bus_b.CYCLE_COUNT, 32'd8);
                chk("to.done",       bus_b.DONE, 1'b1);
                chk("to.timeout",    bus_b.TIMEOUT, 1'b1);
                chk("to.en_off",     bus_b.CPU_EN, 1'b0);
            end
        end
        tick(3);
        chk("to.count_held", bus_b.CYCLE_COUNT, 32'd8);
        bus_b.RUN = 1'b0;

        // Scenario 2: run until HALTED_IN on the 10th enabled cycle.
        bus_a.RUN = 1'b1;
        tick(1);
        chk("halt.state_run", bus_a.STATE, 3'd2);
        tick(9);
        chk("halt.count9", bus_a.CYCLE_COUNT, 32'd9);
        bus_a.HALTED_IN = 1'b1;
        tick(1);
        bus_a.HALTED_IN = 1'b0;
        chk("halt.state_done", bus_a.STATE, 3'd5);
        chk("halt.count",      bus_a.CYCLE_COUNT, 32'd10);
        chk("halt.done",       bus_a.DONE, 1'b1);
        chk("halt.timeout",    bus_a.TIMEOUT, 1'b0);
        chk("halt.en_off",     bus_a.CPU_EN, 1'b0);
        bus_a.RUN = 1'b0; bus_a.STEP = 1'b1;
        tick(1);
        bus_a.STEP = 1'b0; bus_a.RUN = 1'b1;
        tick(2);
        bus_a.HALT_REQ = 1'b1;
        tick(1);
        bus_a.HALT_REQ = 1'b0;
        chk("halt.absorb_state", bus_a.STATE, 3'd5);
        chk("halt.absorb_count", bus_a.CYCLE_COUNT, 32'd10);
        bus_a.RUN = 1'b0;

        // Recover with a reset, then scenario 6: reset mid-run at count 5.
        #1 RESET = 1'b1;
        #1 RESET = 1'b0;
        release_check("rel2");
        bus_a.RUN = 1'b1;
        tick(1);
        tick(5);
        chk("mid.count5", bus_a.CYCLE_COUNT, 32'd5);
        #1 RESET = 1'b1;
        #1;
        chk("mid.CPU_RESET",   bus_a.CPU_RESET, 1'b1);
        chk("mid.CYCLE_COUNT", bus_a.CYCLE_COUNT, 32'd0);
        chk("mid.STATE",       bus_a.STATE, 3'd0);
        chk("mid.CPU_EN",      bus_a.CPU_EN, 1'b0);
        bus_a.RUN = 1'b0;
        RESET = 1'b0;
        release_check("rel3");

        // Scenario 3: pause with RUN held, three steps, resume.
        bus_a.RUN = 1'b1;
        tick(1);
        tick(4);
        bus_a.HALT_REQ = 1'b1;
        tick(1);
        bus_a.HALT_REQ = 1'b0;
        chk("pause.state", bus_a.STATE, 3'd3);
        chk("pause.count", bus_a.CYCLE_COUNT, 32'd5);
        tick(3);
        chk("pause.held_state", bus_a.STATE, 3'd3);
        chk("pause.held_count", bus_a.CYCLE_COUNT, 32'd5);
        for (int s = 0; s < 3; s++) begin
            bus_a.STEP = 1'b1;
            tick(1);
            bus_a.STEP = 1'b0;
            chk($sformatf("step%0d.state", s), bus_a.STATE, 3'd4);
            chk($sformatf("step%0d.en", s), bus_a.CPU_EN, 1'b1);
            tick(1);
            chk($sformatf("step%0d.back", s), bus_a.STATE, 3'd3);
            chk($sformatf("step%0d.en_off", s), bus_a.CPU_EN, 1'b0);
            chk($sformatf("step%0d.count", s), bus_a.CYCLE_COUNT, 32'(6 + s));
        end
        bus_a.RUN = 1'b0;
        tick(1);
        chk("resume.still_paused", bus_a.STATE, 3'd3);
        bus_a.RUN  = 1'b1;
        bus_a.STEP = 1'b1;
        tick(1);
        bus_a.STEP = 1'b0;
        chk("resume.run_wins", bus_a.STATE, 3'd2);
        bus_a.STEP = 1'b1;
        tick(1);
        bus_a.STEP = 1'b0;
        chk("run.step_ignored", bus_a.STATE, 3'd2);

        // Scenario 5: HALTED_IN together with HALT_REQ in RUN.
        bus_a.HALTED_IN = 1'b1;
        bus_a.HALT_REQ  = 1'b1;
        tick(1);
        bus_a.HALTED_IN = 1'b0;
        bus_a.HALT_REQ  = 1'b0;
        chk("prio.state", bus_a.STATE, 3'd5);
        chk("prio.done", bus_a.DONE, 1'b1);
        chk("prio.timeout", bus_a.TIMEOUT, 1'b0);
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
